inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Fetch stage of the single-cycle MIPS datapath, sitting directly upstream of the instruction ROM.
- Owns the PC and drives the ROM word address; the ROM answers combinationally in the same cycle.
- Captures the returned instruction into an IF/ID output register and hands it to decode over a valid/ready handshake.
- Accepts branch/jump redirects (Beq, J) from decode/execute and detects running off the end of ROM.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ROM_WORDS, 32, number of valid 32-bit ROM words; byte addresses at or above ROM_WORDS*4 are out of range

Ports:
Clock  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
rom_addr  output  32  byte address to ROM; ROM indexes with [6:2]
rom_inst  input  32  instruction word returned by ROM, same cycle
id_valid  output  1  IF/ID register holds a valid instruction
id_ready  input  1  decode accepts the IF/ID contents this cycle
id_inst  output  32  fetched instruction
id_pc  output  32  address of id_inst
id_pc4  output  32  id_pc + 4, used for branch target and link
redirect  input  1  load a new PC and flush IF/ID
redirect_pc  input  32  target byte address for the redirect
fetch_done  output  1  PC is out of range and IF/ID has drained
fetch_count  output  32  number of instructions accepted by decode

Behaviour:
- Reset (synchronous, Reset=1 at a Clock edge) takes priority over everything, including mid-stall and a simultaneous redirect. It sets:
  - pc=RESET_PC
  - id_valid=0, id_inst=0, id_pc=0, id_pc4=0
  - fetch_count=0
  - fetch_done then evaluates to 0.
- rom_addr = pc (combinational from the PC register). pc[1:0] is always 00.
- Range check: oor = (pc[31:2] >= ROM_WORDS).
- Handoff: handoff = id_valid & id_ready.
- Capture condition: fire = !oor & (!id_valid | id_ready) & !redirect.
- Priority per edge, after reset: redirect > fire > hold.
- On redirect:
  - pc <= {redirect_pc[31:2], 2'b00}. A misaligned target is silently aligned down.
  - id_valid <= 0; the younger fetched instruction is squashed.
  - No capture occurs that cycle. The first instruction from the target appears in IF/ID one edge later, giving a 2-cycle redirect-to-valid latency.
- On fire:
  - id_inst <= rom_inst, id_pc <= pc, id_pc4 <= pc+4.
  - id_valid <= 1.
  - pc <= pc+4, using 32-bit wrap arithmetic.
- When neither redirect nor fire applies:
  - If handoff, then id_valid <= 0 (the drain case when oor).
  - Otherwise all state holds. This is the stall case: id_valid=1 and id_ready=0 keeps id_inst, id_pc and id_pc4 stable, and rom_addr stays on the next PC.
- Throughput: one instruction per cycle when id_ready stays high; there are no bubbles except after a redirect.
- fetch_count:
  - Increments by 1 on every edge where handoff=1. This includes an edge with a simultaneous redirect, because decode consumed the branch itself.
  - Wraps modulo 2^32.
- fetch_done = oor & !id_valid (combinational). A redirect to an in-range address clears it on the next cycle.
- id_inst, id_pc and id_pc4 are don't-care semantically while id_valid=0, but must keep their last values (no X).
- The block contains no combinational path from id_ready or redirect to rom_addr.

Test Plan:
- Reset, then id_ready=1 with ROM preloaded:
  - rom_addr sequence is 0x0, 0x4, 0x8, ...
  - First three handoffs: (id_pc 0x0, id_inst 0x00002820), (0x4, 0x8CB10000), (0x8, 0x8CB20004).
  - fetch_count=3.
- Stall: drop id_ready for 3 cycles while id_pc=0x4.
  - id_inst holds 0x8CB10000 and rom_addr holds 0x8 throughout.
  - On release, the next edge presents id_pc=0x8.
  - fetch_count does not advance during the stall.
- Redirect while id_valid=1, id_ready=1, with redirect_pc=0x34 (the same cycle counts as a handoff):
  - Next cycle: id_valid=0 and rom_addr=0x34.
  - Following cycle: id_pc=0x34, id_inst=0x8CB20004, id_pc4=0x38.
- Misaligned redirect_pc=0x36: rom_addr becomes 0x34 and the captured id_pc is 0x34.
- End of ROM (ROM_WORDS=32), free-running:
  - Last valid id_pc is 0x7C.
  - After its handoff: id_valid=0, fetch_done=1, rom_addr stuck at 0x80, fetch_count=32.
  - A redirect to 0x0 clears fetch_done and fetching resumes.
- Reset asserted mid-stall (id_valid=1, id_ready=0) together with redirect=1:
  - Next edge: pc=RESET_PC, id_valid=0, fetch_count=0; the redirect is ignored.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Fetch stage of the single-cycle MIPS datapath.
// Owns the PC, drives the instruction ROM address, and captures the returned
// word into an IF/ID register that is handed to decode over valid/ready.
// Branch/jump redirects reload the PC and squash the IF/ID contents.
// Running past the end of the ROM stops fetching; fetch_done is raised once
// the IF/ID register has drained.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_WORDS = 32
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_done,
    output logic [31:0] fetch_count
);

    // Word index limit compared against pc[31:2]
    localparam logic [29:0] ROM_LIMIT        = 30'(ROM_WORDS);
    // The PC is kept word aligned, so the reset value is aligned as well
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc_reg;
    logic [31:0] id_inst_reg;
    logic [31:0] id_pc_reg;
    logic [31:0] id_pc4_reg;
    logic [31:0] fetch_count_reg;
    logic        id_valid_reg;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;
    logic        oor;
    logic        handoff;
    logic        fire;

    // Misaligned redirect targets are silently rounded down to a word
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign pc_plus4        = pc_reg + 32'd4;

    // PC past the last ROM word: no further instructions to fetch
    assign oor     = (pc_reg[31:2] >= ROM_LIMIT);
    assign handoff = id_valid_reg & id_ready;
    // Capture when the IF/ID slot is free or being emptied this cycle,
    // unless a redirect squashes the fetch
    assign fire    = !oor & (!id_valid_reg | id_ready) & !redirect;

    // ROM address comes straight from the PC register; no path from
    // id_ready or redirect reaches it
    assign rom_addr    = pc_reg;
    assign id_valid    = id_valid_reg;
    assign id_inst     = id_inst_reg;
    assign id_pc       = id_pc_reg;
    assign id_pc4      = id_pc4_reg;
    assign fetch_count = fetch_count_reg;
    assign fetch_done  = oor & !id_valid_reg;

    // PC / IF/ID register update: reset > redirect > capture > drain > hold
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_reg       <= RESET_PC_ALIGNED;
            id_valid_reg <= 1'b0;
            id_inst_reg  <= 32'd0;
            id_pc_reg    <= 32'd0;
            id_pc4_reg   <= 32'd0;
        end else if (redirect) begin
            pc_reg       <= redirect_target;
            id_valid_reg <= 1'b0;
        end else if (fire) begin
            id_inst_reg  <= rom_inst;
            id_pc_reg    <= pc_reg;
            id_pc4_reg   <= pc_plus4;
            id_valid_reg <= 1'b1;
            pc_reg       <= pc_plus4;
        end else if (handoff) begin
            id_valid_reg <= 1'b0;
        end
    end

    // Count every instruction decode consumes, including a branch that
    // triggers a redirect in the same cycle
    always_ff @(posedge Clock) begin
        if (Reset) begin
            fetch_count_reg <= 32'd0;
        end else if (handoff) begin
            fetch_count_reg <= fetch_count_reg + 32'd1;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: directed stimulus with a scoreboard of
// expected IF/ID handoffs, popped by an independent monitor.
module tb_inst_fetch_unit;

    logic        Clock;
    logic        Reset;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_done;
    logic [31:0] fetch_count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] rom [0:31];
    int          n_cmp = 0;
    int          n_bad = 0;

    inst_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .ROM_WORDS (32)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .rom_addr    (rom_addr),
        .rom_inst    (rom_inst),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_done  (fetch_done),
        .fetch_count (fetch_count)
    );

    // Combinational ROM model
    assign rom_inst = rom[rom_addr[6:2]];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        sb.push_back(e);
    endtask

    // Monitor: every handoff must match the oldest expected entry
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (!Reset && id_valid && id_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL handoff_unexpected: got id_pc %h, expected no handoff", id_pc);
                end else begin
                    e = sb.pop_front();
                    chk("handoff_pc", id_pc, e.pc);
                    chk("handoff_inst", id_inst, e.inst);
                    chk("handoff_pc4", id_pc4, e.pc + 32'd4);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        bit seen_done;
        for (int i = 0; i < 32; i++) rom[i] = {8'hA5, 8'(i), 16'(i * 4)};
        rom[0]  = 32'h0000_2820;
        rom[1]  = 32'h8CB1_0000;
        rom[2]  = 32'h8CB2_0004;
        rom[13] = 32'h8CB2_0004;

        Reset = 1'b1; id_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        tick();
        tick();
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_rom_addr", rom_addr, 32'h0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_done", {31'd0, fetch_done}, 32'd0);
        chk("rst_id_inst", id_inst, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);

        // Streaming fetch with decode always ready
        push(32'h0, 32'h0000_2820);
        push(32'h4, 32'h8CB1_0000);
        push(32'h8, 32'h8CB2_0004);
        push(32'hC, rom[3]);
        Reset = 1'b0; id_ready = 1'b1;
        tick();                                   // capture 0x0
        chk("e1_id_pc", id_pc, 32'h0);
        chk("e1_rom_addr", rom_addr, 32'h4);
        tick();                                   // handoff 0x0, capture 0x4
        chk("e2_id_pc", id_pc, 32'h4);
        chk("e2_rom_addr", rom_addr, 32'h8);
        chk("e2_count", fetch_count, 32'd1);

        // Stall three cycles holding 0x4
        id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_id_inst", id_inst, 32'h8CB1_0000);
            chk("stall_rom_addr", rom_addr, 32'h8);
            chk("stall_count", fetch_count, 32'd1);
        end
        id_ready = 1'b1;
        tick();                                   // handoff 0x4, capture 0x8
        chk("rel_id_pc", id_pc, 32'h8);
        chk("rel_count", fetch_count, 32'd2);
        tick();                                   // handoff 0x8, capture 0xC
        chk("e7_count", fetch_count, 32'd3);
        chk("e7_rom_addr", rom_addr, 32'h10);

        // Redirect to 0x34 while 0xC is handed off
        redirect = 1'b1; redirect_pc = 32'h34;
        tick();
        chk("redir_id_valid", {31'd0, id_valid}, 32'd0);
        chk("redir_rom_addr", rom_addr, 32'h34);
        chk("redir_count", fetch_count, 32'd4);
        redirect = 1'b0;
        push(32'h34, 32'h8CB2_0004);
        tick();
        chk("tgt_id_valid", {31'd0, id_valid}, 32'd1);
        chk("tgt_id_pc", id_pc, 32'h34);
        chk("tgt_id_inst", id_inst, 32'h8CB2_0004);
        chk("tgt_id_pc4", id_pc4, 32'h38);
        push(32'h38, rom[14]);
        tick();                                   // handoff 0x34, capture 0x38

        // Misaligned redirect target
        redirect = 1'b1; redirect_pc = 32'h36;
        tick();                                   // handoff 0x38, redirect
        chk("mis_rom_addr", rom_addr, 32'h34);
        chk("mis_count", fetch_count, 32'd6);
        redirect = 1'b0;
        push(32'h34, 32'h8CB2_0004);
        tick();
        chk("mis_id_pc", id_pc, 32'h34);

        // Reset during a stall together with a redirect
        id_ready = 1'b0;
        tick();
        chk("pre_rst_id_pc", id_pc, 32'h34);
        chk("pre_rst_valid", {31'd0, id_valid}, 32'd1);
        Reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        chk("mid_rst_rom_addr", rom_addr, 32'h0);
        chk("mid_rst_valid", {31'd0, id_valid}, 32'd0);
        chk("mid_rst_count", fetch_count, 32'd0);
        chk("mid_rst_done", {31'd0, fetch_done}, 32'd0);
        sb.delete();

        // Free-run from reset off the end of the ROM
        for (int i = 0; i < 32; i++) push(32'(i * 4), rom[i]);
        Reset = 1'b0; redirect = 1'b0; id_ready = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 100 && !seen_done; k++) begin
            tick();
            if (fetch_done) seen_done = 1'b1;
        end
        chk("end_done_seen", {31'd0, seen_done}, 32'd1);
        chk("end_count", fetch_count, 32'd32);
        chk("end_rom_addr", rom_addr, 32'h80);
        chk("end_id_valid", {31'd0, id_valid}, 32'd0);
        chk("end_last_pc", id_pc, 32'h7C);
        tick();
        tick();
        chk("end_hold_rom_addr", rom_addr, 32'h80);
        chk("end_hold_count", fetch_count, 32'd32);
        chk("end_hold_done", {31'd0, fetch_done}, 32'd1);

        // Redirect back into range resumes fetching
        redirect = 1'b1; redirect_pc = 32'h0;
        tick();
        chk("resume_done", {31'd0, fetch_done}, 32'd0);
        chk("resume_rom_addr", rom_addr, 32'h0);
        redirect = 1'b0;
        push(32'h0, 32'h0000_2820);
        tick();
        chk("resume_id_pc", id_pc, 32'h0);
        chk("resume_valid", {31'd0, id_valid}, 32'd1);
        tick();
        chk("resume_count", fetch_count, 32'd33);
        id_ready = 1'b0;
        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
